// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg
// Shared definitions for the count_monitor block: the legal range of the
// observed counter, the monitor state enumeration and the active-low
// 7-segment code table ({g,f,e,d,c,b,a}).
package count_monitor_pkg;

  localparam logic [3:0] CNT_MIN = 4'd2;
  localparam logic [3:0] CNT_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment codes for digits 0..9, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_CODES [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Codes above 9 are not decimal digits and are shown blank.
  function automatic logic [6:0] seg7_code(input logic [3:0] value);
    if (value <= 4'd9) begin
      return SEG_CODES[value];
    end
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   value  in   4  digit to display (10..15 give a blank pattern)
//   seg    out  7  active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import count_monitor_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = seg7_code(value);

endmodule

// File: rtl/count_monitor.sv
// count_monitor
// Watches an external 2..9 up/down counter ({Qd,Qc,Qb,Qa}, direction M,
// active-low carry/borrow _Qcc) and checks that every sample is the legal
// successor of the previous one, that the carry pulses exactly after the
// terminal value, and counts wrap-arounds.
//
// Configuration macro: COUNT_MONITOR_SEG7_EN
//   defined   -> seg is the registered 7-segment decode of digit
//   undefined -> no decoder, seg tied to 7'h7F (all segments off)
//
// Ports:
//   CP       in   1  clock, rising edge
//   CLR      in   1  asynchronous active-high reset
//   M        in   1  observed count direction (1=up, 0=down)
//   Qa..Qd   in   1  observed counter value, Qa = LSB
//   _Qcc     in   1  observed active-low carry/borrow
//   digit    out  4  last accepted sample
//   wraps    out  4  BCD count of legal wrap-arounds
//   locked   out  1  high while tracking
//   seq_err  out  1  sticky error flag
//   err_cnt  out  8  saturating error count
//   seg      out  7  active-low segment pattern of digit
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_SYNC  | waiting for an in-range sample to start tracking
// ST_TRACK | each sample checked against the legal successor and carry
// ST_ERR   | last check failed; next in-range sample restarts tracking
module count_monitor
  import count_monitor_pkg::*;
(
  input  logic       CP,
  input  logic       CLR,
  input  logic       M,
  input  logic       Qa,
  input  logic       Qb,
  input  logic       Qc,
  input  logic       Qd,
  input  logic       _Qcc,
  output logic [3:0] digit,
  output logic [3:0] wraps,
  output logic       locked,
  output logic       seq_err,
  output logic [7:0] err_cnt,
  output logic [6:0] seg
);

  state_t     state;
  logic       prev_m;

  logic [3:0] sample;
  logic [3:0] succ;
  logic       in_range;
  logic       dir_change;
  logic       carry_need;
  logic       track_ok;
  logic       digit_load;
  logic       error_ev;
  logic       wrap_ev;
  logic [3:0] digit_nxt;

  always_comb begin
    sample   = {Qd, Qc, Qb, Qa};
    in_range = (sample >= CNT_MIN) && (sample <= CNT_MAX);

    // Successor and carry expectation follow the direction registered with
    // the previous sample, not the one arriving now.
    if (prev_m) begin
      carry_need = (digit == CNT_MAX);
      succ       = carry_need ? CNT_MIN : digit + 4'd1;
    end else begin
      carry_need = (digit == CNT_MIN);
      succ       = carry_need ? CNT_MAX : digit - 4'd1;
    end

    dir_change = (M != prev_m);
    // A direction change suppresses both the value and the carry check.
    track_ok   = dir_change || ((sample == succ) && (_Qcc != carry_need));

    // One error per edge no matter how many checks failed.
    error_ev   = (state == ST_TRACK) && !(in_range && track_ok);
    wrap_ev    = (state == ST_TRACK) && in_range && !dir_change && track_ok && carry_need;
    digit_load = in_range && ((state != ST_TRACK) || track_ok);
    digit_nxt  = digit_load ? sample : digit;
  end

  always_ff @(posedge CP or posedge CLR) begin
    if (CLR) begin
      state   <= ST_SYNC;
      prev_m  <= 1'b1;
      digit   <= CNT_MIN;
      wraps   <= 4'd0;
      locked  <= 1'b0;
      seq_err <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      prev_m <= M;
      if (digit_load) begin
        digit <= sample;
      end
      if (wrap_ev) begin
        wraps <= (wraps == 4'd9) ? 4'd0 : wraps + 4'd1;
      end
      if (error_ev) begin
        seq_err <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end

      case (state)
        ST_SYNC: begin
          if (in_range) begin
            state  <= ST_TRACK;
            locked <= 1'b1;
          end
        end
        ST_TRACK: begin
          if (!in_range) begin
            state  <= ST_SYNC;
            locked <= 1'b0;
          end else if (!track_ok) begin
            state  <= ST_ERR;
            locked <= 1'b0;
          end
        end
        ST_ERR: begin
          if (in_range) begin
            state  <= ST_TRACK;
            locked <= 1'b1;
          end else begin
            state  <= ST_SYNC;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= ST_SYNC;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNT_MONITOR_SEG7_EN
  logic [6:0] seg_nxt;

  // Decode the value digit is about to take so seg lines up with digit.
  seg7_decode u_seg7_decode (
    .value (digit_nxt),
    .seg   (seg_nxt)
  );

  always_ff @(posedge CP or posedge CLR) begin
    if (CLR) begin
      seg <= seg7_code(CNT_MIN);
    end else begin
      seg <= seg_nxt;
    end
  end
`else
  logic unused_digit_nxt;
  assign unused_digit_nxt = ^digit_nxt;
  assign seg = SEG_BLANK;
`endif

endmodule
